// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg -- shared definitions for the push-button conditioner.
//
// Contents:
//   rpt_state_e   : per-channel auto-repeat FSM states (IDLE, DELAY, REPEAT)
//   idx_width()   : $clog2 with a floor of 1, for index/timer widths that must
//                   never collapse to zero bits
//   DIR_*         : channel indices of the snake game direction buttons, so
//                   game cores can decode cmd_idx without magic numbers
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  // Number of bits needed to hold the values 0..n-1, never less than 1.
  function automatic int idx_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : btn_pkg

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel -- conditioning for a single push-button bit.
//
// Pipeline: 2-flop synchroniser -> stable-count debouncer -> registered
// press/release edge pulses -> optional auto-repeat FSM.
//
// Build option: define BTN_AUTO_REPEAT_EN to build the auto-repeat FSM and
// timer; without it repeat_o is a constant 0 and no repeat logic exists.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   raw_i      in   asynchronous noisy button input, 1 = pressed
//   level_o    out  debounced level
//   press_o    out  1-cycle pulse, first cycle the debounced level reads 1
//   release_o  out  1-cycle pulse, first cycle the debounced level reads 0
//   repeat_o   out  1-cycle auto-repeat pulse while the button stays held
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Catch impossible timing configurations at elaboration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_channel: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer and edge pulses
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;

  always_comb begin
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync2_q == level_q) begin
      // Any agreement restarts the count, so a glitch leaves no trace.
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Pulses are registered alongside the level so they appear in exactly
    // the cycle the new level first becomes visible.
    level_d   = accept ? sync2_q : level_q;
    press_d   = accept & sync2_q;
    release_d = accept & ~sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = idx_width(RPT_MAX);

  rpt_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             repeat_q, repeat_d;

  // The FSM reacts to the debounce decision (press_d/release_d) rather than
  // the registered pulses, so the timer is loaded on the same edge that
  // raises press_q. That keeps the first repeat exactly REPEAT_DELAY cycles
  // after the press pulse and lets a release suppress a coincident repeat.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    repeat_d = 1'b0;
    if (release_d) begin
      state_d = IDLE;
    end else if (press_d) begin
      state_d = DELAY;
      tmr_d   = TMR_W'(REPEAT_DELAY - 1);
    end else begin
      case (state_q)
        DELAY, REPEAT: begin
          if (tmr_q == '0) begin
            repeat_d = 1'b1;
            state_d  = REPEAT;
            tmr_d    = TMR_W'(REPEAT_PERIOD - 1);
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        default: begin
          tmr_d = tmr_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule : btn_channel

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner -- conditions NUM_CH active-high push-buttons and produces a
// single encoded command per cycle for the game logic.
//
// Each channel (btn_channel) synchronises, debounces and edge-detects one
// button; an optional auto-repeat FSM per channel emits repeat pulses while a
// button is held. A lowest-index-wins arbiter over (press | repeat) drives
// cmd_valid/cmd_idx in the same cycle as the pulses. Losing requests are
// dropped, not queued.
//
// Build option: define BTN_AUTO_REPEAT_EN to enable auto-repeat. Without it
// btn_repeat is 0 and the arbiter effectively sees btn_press only.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn_raw      in   [NUM_CH]  noisy asynchronous buttons, 1 = pressed
//   btn_level    out  [NUM_CH]  debounced levels
//   btn_press    out  [NUM_CH]  1-cycle pulse on debounced 0->1
//   btn_release  out  [NUM_CH]  1-cycle pulse on debounced 1->0
//   btn_repeat   out  [NUM_CH]  1-cycle auto-repeat pulses
//   cmd_valid    out  any press/repeat pulse this cycle
//   cmd_idx      out  lowest channel index with a press/repeat; 0 when idle
// -----------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            btn_raw,
  output logic [NUM_CH-1:0]            btn_level,
  output logic [NUM_CH-1:0]            btn_press,
  output logic [NUM_CH-1:0]            btn_release,
  output logic [NUM_CH-1:0]            btn_repeat,
  output logic                         cmd_valid,
  output logic [idx_width(NUM_CH)-1:0] cmd_idx
);

  localparam int IDX_W = idx_width(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("btn_conditioner: NUM_CH must be in 1..16");
  end

  // ---------------------------------------------------------------------------
  // Per-channel conditioning
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (btn_raw[gi]),
      .level_o   (btn_level[gi]),
      .press_o   (btn_press[gi]),
      .release_o (btn_release[gi]),
      .repeat_o  (btn_repeat[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Command arbiter: purely combinational from the registered pulses so the
  // command lines up with the pulse cycle. Scanning from the top down lets the
  // lowest set index overwrite any higher one.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] cmd_req;

  assign cmd_req = btn_press | btn_repeat;

  always_comb begin
    cmd_valid = |cmd_req;
    cmd_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cmd_req[i]) begin
        cmd_idx = IDX_W'(i);
      end
    end
  end

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner -- scoreboard bench for btn_conditioner with
// NUM_CH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
//
// Every stimulus task pushes the events it must cause (press, release,
// repeat, reset-clear) with their due cycle; a negedge monitor pops the
// events due each cycle, rebuilds the expected output vectors and compares
// all DUT outputs every cycle. Honour BTN_AUTO_REPEAT_EN the same way the
// DUT build does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btn_conditioner;

  localparam int NCH = 4;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = 2 + DB;   // raw change to visible level

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_REPEAT  = 2;
  localparam int EV_CLR     = 3;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] btn_raw;
  logic [NCH-1:0] btn_level, btn_press, btn_release, btn_repeat;
  logic           cmd_valid;
  logic [1:0]     cmd_idx;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  ev_t sb[$];

  logic [NCH-1:0] exp_lvl = '0;
  logic [NCH-1:0] exp_p, exp_rl, exp_rp, exp_req;
  logic           exp_valid;
  logic [1:0]     exp_idx;
  bit             exp_clr;
  bit             found;

  btn_conditioner #(
    .NUM_CH          (NCH),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .cmd_valid   (cmd_valid),
    .cmd_idx     (cmd_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  // Press visible at p_cyc, release visible at r_cyc (r_cyc < 0: none).
  // Repeats fall at p+RD, p+RD+RP, ... strictly before the release cycle.
  task automatic push_hold_events(input int ch, input int p_cyc, input int r_cyc);
    push_ev(p_cyc, ch, EV_PRESS);
    if (r_cyc >= 0) begin
      push_ev(r_cyc, ch, EV_RELEASE);
`ifdef BTN_AUTO_REPEAT_EN
      for (int rp = p_cyc + RD; rp < r_cyc; rp += RP) begin
        push_ev(rp, ch, EV_REPEAT);
      end
`endif
    end
  endtask

  // Hold the buttons in mask for 'hold' cycles; optionally drop them for
  // DB-1 cycles starting 'glitch_at' cycles into the hold.
  task automatic hold_btn(input logic [NCH-1:0] mask, input int hold, input int glitch_at);
    int t;
    t = cyc;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) push_hold_events(ch, t + LAT, t + hold + LAT);
    end
    btn_raw = btn_raw | mask;
    for (int i = 0; i < hold; i++) begin
      if (glitch_at > 0 && i == glitch_at)          btn_raw = btn_raw & ~mask;
      if (glitch_at > 0 && i == glitch_at + DB - 1) btn_raw = btn_raw | mask;
      wait_cycles(1);
    end
    btn_raw = btn_raw & ~mask;
    $display("txn hold mask=%b from cyc %0d for %0d cycles glitch_at=%0d", mask, t, hold, glitch_at);
  endtask

  // Monitor: compare every output every cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_p   = '0;
      exp_rl  = '0;
      exp_rp  = '0;
      exp_clr = 1'b0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            EV_PRESS:   exp_p[sb[i].ch]  = 1'b1;
            EV_RELEASE: exp_rl[sb[i].ch] = 1'b1;
            EV_REPEAT:  exp_rp[sb[i].ch] = 1'b1;
            default:    exp_clr          = 1'b1;
          endcase
          sb.delete(i);
        end
      end
      if (exp_clr) exp_lvl = '0;
      exp_lvl   = (exp_lvl | exp_p) & ~exp_rl;
      exp_req   = exp_p | exp_rp;
      exp_valid = (exp_req != '0);
      exp_idx   = '0;
      found     = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (exp_req[i] && !found) begin
          exp_idx = 2'(i);
          found   = 1'b1;
        end
      end
      check_eq("btn_level",   32'(btn_level),   32'(exp_lvl));
      check_eq("btn_press",   32'(btn_press),   32'(exp_p));
      check_eq("btn_release", 32'(btn_release), 32'(exp_rl));
      check_eq("btn_repeat",  32'(btn_repeat),  32'(exp_rp));
      check_eq("cmd_valid",   32'(cmd_valid),   32'(exp_valid));
      check_eq("cmd_idx",     32'(cmd_idx),     32'(exp_idx));
    end
  end

  initial begin
    int t;
    int r;
    reset   = 1'b1;
    btn_raw = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    $display("txn reset released at cyc %0d", cyc);

    // Channel 2 rises at cycle 10 and holds, with a DB-1 low glitch mid-hold.
    wait_cycles(10 - cyc);
    hold_btn(4'b0100, 30, 12);
    wait_cycles(10);

    // Channel 0 high for DB-1 cycles only: no level change, no pulses.
    btn_raw[0] = 1'b1;
    wait_cycles(DB - 1);
    btn_raw[0] = 1'b0;
    $display("txn glitch ch0 for %0d cycles", DB - 1);
    wait_cycles(10);

    // Channel 0 high for exactly DB cycles: accepted.
    hold_btn(4'b0001, DB, 0);
    wait_cycles(12);

    // Channel 1 long hold; release lands on a would-be repeat cycle.
    hold_btn(4'b0010, 25, 0);
    wait_cycles(12);

    // Channels 3 and 1 together: lowest index wins, 3 is dropped.
    hold_btn(4'b1010, 8, 0);
    wait_cycles(12);

    // Channel 3 alone reports index 3.
    hold_btn(4'b1000, 5, 0);
    wait_cycles(12);

    // Reset while channel 0 is held; the hold becomes a new press.
    t = cyc;
    btn_raw[0] = 1'b1;
    push_hold_events(0, t + LAT, -1);
    wait_cycles(LAT + 2);
    reset = 1'b1;
    push_ev(cyc + 1, 0, EV_CLR);
    $display("txn reset asserted at cyc %0d with ch0 held", cyc);
    wait_cycles(2);
    reset = 1'b0;
    r = cyc + 14;
    push_hold_events(0, cyc + LAT, r + LAT);
    $display("txn reset released at cyc %0d with ch0 held", cyc);
    wait_cycles(14);
    btn_raw[0] = 1'b0;
    wait_cycles(20);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_btn_conditioner
